// File: rtl/axi4lite_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_sort_engine
// Brief    : AXI4-Lite slave that sorts N_ELEM words with an odd-even
//            transposition network, one compare-exchange phase per cycle.
// Revision : 1.0
// ============================================================================
module axi4lite_sort_engine #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int N_ELEM             = 8,
    parameter int SIGNED_CMP         = 0
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);
    localparam int c_DW = C_S_AXI_DATA_WIDTH;
    localparam int c_WI = C_S_AXI_ADDR_WIDTH - 2;
    localparam int c_PW = $clog2(N_ELEM);
    localparam logic [c_WI-1:0] c_IDX_CTRL   = c_WI'(0);
    localparam logic [c_WI-1:0] c_IDX_STATUS = c_WI'(1);
    localparam logic [c_WI-1:0] c_IDX_DATA   = c_WI'(4);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SORT = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_awready, r_bvalid, r_arready, r_rvalid;
    logic [c_DW-1:0]   r_rdata;
    logic              r_desc, r_irq_en, r_sort_desc, r_done;
    logic [c_PW-1:0]   r_phase;
    logic [c_DW-1:0]   r_data   [N_ELEM];
    logic [c_DW-1:0]   w_sorted [N_ELEM];
    logic [c_DW-1:0]   w_rd_mux;
    logic [c_WI-1:0]   w_wr_idx, w_rd_idx;
    logic              w_wr_en, w_rd_en, w_ctrl_sel, w_start, w_done_clr;
    logic              w_desc_wr, w_last, w_busy;
    logic              w_unused;

    assign w_wr_en    = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_en    = r_arready & S_AXI_ARVALID;
    assign w_wr_idx   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_busy     = (r_state == S_SORT);
    assign w_ctrl_sel = w_wr_en && (w_wr_idx == c_IDX_CTRL);
    assign w_start    = w_ctrl_sel && S_AXI_WDATA[0] && !w_busy;
    assign w_done_clr = w_wr_en && (w_wr_idx == c_IDX_STATUS) && S_AXI_WDATA[1];
    assign w_desc_wr  = (w_ctrl_sel && S_AXI_WSTRB[0]) ? S_AXI_WDATA[1] : r_desc;
    assign w_last     = (r_phase == c_PW'(N_ELEM - 1));
    assign w_unused   = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_rvalid;
    assign irq           = r_done & r_irq_en;

    function automatic logic f_swap(input logic [c_DW-1:0] a,
                                    input logic [c_DW-1:0] b,
                                    input logic            desc);
        logic gt, lt;
        if (SIGNED_CMP != 0) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return desc ? lt : gt;
    endfunction

    // Ready is raised only while both valids wait, so each pulse is one transfer
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= !r_awready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
            if (w_wr_en)
                r_bvalid <= 1'b1;
            else if (S_AXI_BREADY)
                r_bvalid <= 1'b0;
            r_arready <= !r_arready && S_AXI_ARVALID && !r_rvalid;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_rd_idx == c_IDX_CTRL) begin
            w_rd_mux[2:1] = {r_irq_en, r_desc};
        end else if (w_rd_idx == c_IDX_STATUS) begin
            w_rd_mux[0]    = w_busy;
            w_rd_mux[1]    = r_done;
            w_rd_mux[15:8] = 8'(N_ELEM);
        end
        for (int i = 0; i < N_ELEM; i++) begin
            if (w_rd_idx == c_IDX_DATA + c_WI'(i))
                w_rd_mux = r_data[i];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_desc      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_sort_desc <= 1'b0;
            r_done      <= 1'b0;
            r_phase     <= '0;
        end else begin
            r_desc <= w_desc_wr;
            if (w_ctrl_sel && S_AXI_WSTRB[0])
                r_irq_en <= S_AXI_WDATA[2];
            if (w_start) begin
                r_sort_desc <= w_desc_wr;
                r_phase     <= '0;
            end else if (w_busy) begin
                r_phase <= r_phase + 1'b1;
            end
            // Completion outranks a same-cycle clear; START outranks both
            if (w_start)
                r_done <= 1'b0;
            else if (w_busy && w_last)
                r_done <= 1'b1;
            else if (w_done_clr)
                r_done <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SORT;
            S_SORT:  if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
    always_comb begin
        w_sorted = r_data;
        for (int k = 0; k < N_ELEM - 1; k++) begin
            if ((k[0] == r_phase[0]) && f_swap(r_data[k], r_data[k+1], r_sort_desc)) begin
                w_sorted[k]   = r_data[k+1];
                w_sorted[k+1] = r_data[k];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < N_ELEM; i++)
                r_data[i] <= '0;
        end else if (w_busy) begin
            r_data <= w_sorted;
        end else if (w_wr_en) begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (w_wr_idx == c_IDX_DATA + c_WI'(i)) begin
                    for (int b = 0; b < c_DW / 8; b++) begin
                        if (S_AXI_WSTRB[b])
                            r_data[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi4lite_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_sort_engine
// Brief    : Self-checking bench with a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_axi4lite_sort_engine;
    localparam int N   = 8;
    localparam int AW  = 6;
    localparam int SGN = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic          S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic          S_AXI_BREADY = 1'b1, S_AXI_RREADY = 1'b1;
    logic [31:0]   S_AXI_WDATA = '0;
    logic [3:0]    S_AXI_WSTRB = 4'hF;
    logic          S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, irq;
    logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0]   S_AXI_RDATA;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi4lite_sort_engine #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .N_ELEM(N), .SIGNED_CMP(SGN)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_arr [N] = '{default: 32'h0};
    bit          m_busy, m_done, m_irqen, m_desc, m_sdesc, m_rpend, m_rok;
    int          m_cnt;
    logic [31:0] m_rexp;

    function automatic bit m_before(input logic [31:0] a, input logic [31:0] b, input bit desc);
        bit lt;
        lt = (SGN != 0) ? ($signed(a) < $signed(b)) : (a < b);
        if (desc)
            return (SGN != 0) ? ($signed(a) > $signed(b)) : (a > b);
        return lt;
    endfunction

    function automatic void m_sort();
        int best;
        logic [31:0] t;
        for (int i = 0; i < N; i++) begin
            best = i;
            for (int j = i + 1; j < N; j++)
                if (m_before(m_arr[j], m_arr[best], m_sdesc)) best = j;
            t = m_arr[i]; m_arr[i] = m_arr[best]; m_arr[best] = t;
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [AW-1:0] a, output bit ok);
        int w;
        w = int'(a[AW-1:2]);
        ok = 1;
        if (w == 0) return {29'b0, m_irqen, m_desc, 1'b0};
        if (w == 1) return (32'(N) << 8) | {30'b0, m_done, m_busy};
        if (w >= 4 && w < 4 + N) begin
            ok = !m_busy;
            return m_arr[w-4];
        end
        return 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin : p_model
        bit was_busy, fin;
        int w;
        if (rst) begin
            m_busy = 0; m_done = 0; m_irqen = 0; m_desc = 0; m_sdesc = 0;
            m_cnt = 0; m_rpend = 0; m_rok = 0;
            for (int i = 0; i < N; i++) m_arr[i] = 32'h0;
        end else begin
            was_busy = m_busy;
            fin = 0;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                m_rexp  = m_read(S_AXI_ARADDR, m_rok);
                m_rpend = 1;
            end
            if (was_busy) begin
                m_cnt--;
                if (m_cnt == 0) fin = 1;
            end
            if (S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WVALID && S_AXI_WREADY) begin
                w = int'(S_AXI_AWADDR[AW-1:2]);
                if (w == 1 && S_AXI_WDATA[1]) m_done = 0;
                if (w == 0) begin
                    if (S_AXI_WSTRB[0]) begin
                        m_desc  = S_AXI_WDATA[1];
                        m_irqen = S_AXI_WDATA[2];
                    end
                    if (S_AXI_WDATA[0] && !was_busy) begin
                        m_busy = 1; m_cnt = N; m_done = 0; m_sdesc = m_desc;
                    end
                end
                if (w >= 4 && w < 4 + N && !was_busy)
                    for (int b = 0; b < 4; b++)
                        if (S_AXI_WSTRB[b]) m_arr[w-4][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
            if (fin) begin
                m_busy = 0; m_done = 1; m_sort();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        p_bvalid = 0, p_bready = 0, p_rvalid = 0, p_rready = 0;
    logic [31:0] p_rdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            p_bvalid = 0; p_bready = 0; p_rvalid = 0; p_rready = 0;
        end else begin
            chk("irq", 32'(irq), 32'(m_done & m_irqen));
            if (S_AXI_BVALID) begin
                chk("bresp", 32'(S_AXI_BRESP), 32'h0);
                chk("awready_while_b", 32'(S_AXI_AWREADY), 32'h0);
            end
            if (S_AXI_RVALID) chk("rresp", 32'(S_AXI_RRESP), 32'h0);
            if (p_bvalid && !p_bready) chk("bvalid_hold", 32'(S_AXI_BVALID), 32'h1);
            if (p_rvalid && !p_rready) begin
                chk("rvalid_hold", 32'(S_AXI_RVALID), 32'h1);
                chk("rdata_hold", S_AXI_RDATA, p_rdata);
            end
            if (m_rpend) begin
                m_rpend = 0;
                chk("rvalid_latency", 32'(S_AXI_RVALID), 32'h1);
                if (m_rok) chk("rdata_model", S_AXI_RDATA, m_rexp);
            end
            p_bvalid = S_AXI_BVALID; p_bready = S_AXI_BREADY;
            p_rvalid = S_AXI_RVALID; p_rready = S_AXI_RREADY; p_rdata = S_AXI_RDATA;
        end
    end

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 100);
        if (!S_AXI_AWREADY) chk("aw_timeout", 32'(S_AXI_AWREADY), 32'h1);
        @(posedge clk); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        n = 0;
        while (!S_AXI_BVALID && n < 100) begin @(negedge clk); n++; end
        if (!S_AXI_BVALID) chk("b_timeout", 32'(S_AXI_BVALID), 32'h1);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_ARREADY && n < 100);
        if (!S_AXI_ARREADY) chk("ar_timeout", 32'(S_AXI_ARREADY), 32'h1);
        @(posedge clk); #1;
        S_AXI_ARVALID = 0;
        n = 0;
        while (!S_AXI_RVALID && n < 100) begin @(negedge clk); n++; end
        if (!S_AXI_RVALID) chk("r_timeout", 32'(S_AXI_RVALID), 32'h1);
        d = S_AXI_RDATA;
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        int n;
        n = 0;
        do begin axi_read(6'h04, d); n++; end while (d[0] && n < 40);
        chk("busy_timeout", 32'(d[0]), 32'h0);
    endtask

    task automatic load(input logic [31:0] v [N]);
        for (int i = 0; i < N; i++) axi_write(6'(16 + 4*i), v[i], 4'hF);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v [N];
        logic [31:0] exp3 [N];
        logic [31:0] d;
        int n;
        bit desc, ien;

        #1 rst = 1;
        #199;
        chk("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
        chk("rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
        chk("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
        chk("rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk); rst = 0;
        rd_chk("reset_status", 6'h04, 32'h0000_0800);

        // ascending sort; IRQ_EN set so BUSY length is visible on irq
        v = '{32'd7, 32'd3, 32'd8, 32'd1, 32'd6, 32'd2, 32'd5, 32'd4};
        load(v);
        axi_write(6'h00, 32'h5, 4'hF);
        n = 0;
        while (!irq && n < 50) begin @(negedge clk); n++; end
        chk("cycles_to_done", 32'(n), 32'd9);
        for (int i = 0; i < N; i++) rd_chk("asc_data", 6'(16 + 4*i), 32'(i + 1));
        rd_chk("asc_status", 6'h04, 32'h0000_0802);
        axi_write(6'h04, 32'h2, 4'hF);
        rd_chk("done_cleared", 6'h04, 32'h0000_0800);

        // descending signed sort with irq
        v    = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd3, 32'hFFFF_FFFE, 32'd7, 32'd1};
        exp3 = '{32'd7, 32'd5, 32'd3, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
        load(v);
        axi_write(6'h00, 32'h7, 4'hF);
        wait_idle();
        chk("desc_irq_high", 32'(irq), 32'h1);
        for (int i = 0; i < N; i++) rd_chk("desc_data", 6'(16 + 4*i), exp3[i]);
        rd_chk("ctrl_readback", 6'h00, 32'h6);
        axi_write(6'h04, 32'h2, 4'hF);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'h0);

        // writes during BUSY are ignored
        axi_write(6'h00, 32'h0, 4'hF);
        v = '{32'd40, 32'd10, 32'd30, 32'd20, 32'd80, 32'd60, 32'd70, 32'd50};
        load(v);
        axi_write(6'h00, 32'h1, 4'hF);
        axi_write(6'h10, 32'hDEAD, 4'hF);
        axi_write(6'h00, 32'h1, 4'hF);
        wait_idle();
        for (int i = 0; i < N; i++) rd_chk("busy_prot", 6'(16 + 4*i), 32'(10 * (i + 1)));

        // handshake stalls
        S_AXI_BREADY = 0;
        @(posedge clk); #1;
        S_AXI_AWADDR = 6'h14; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 50);
        chk("hs_aw1", 32'(S_AXI_AWREADY), 32'h1);
        @(posedge clk); #1;
        S_AXI_AWADDR = 6'h1C; S_AXI_WDATA = 32'h66;
        repeat (5) begin
            @(negedge clk);
            chk("hs_no_aw2", 32'(S_AXI_AWREADY), 32'h0);
            chk("hs_bvalid", 32'(S_AXI_BVALID), 32'h1);
        end
        @(posedge clk); #1;
        S_AXI_BREADY = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 50);
        chk("hs_aw2", 32'(S_AXI_AWREADY), 32'h1);
        @(posedge clk); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        S_AXI_RREADY = 0;
        @(posedge clk); #1;
        S_AXI_ARADDR = 6'h14; S_AXI_ARVALID = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_ARREADY && n < 50);
        @(posedge clk); #1;
        S_AXI_ARVALID = 0;
        repeat (5) begin
            @(negedge clk);
            chk("hs_rvalid", 32'(S_AXI_RVALID), 32'h1);
            chk("hs_rdata", S_AXI_RDATA, 32'h55);
        end
        @(posedge clk); #1;
        S_AXI_RREADY = 1;
        rd_chk("hs_second_write", 6'h1C, 32'h66);

        // edges
        rd_chk("unmapped_3c", 6'h3C, 32'h0);
        rd_chk("unmapped_08", 6'h08, 32'h0);
        axi_write(6'h18, 32'h1122_3344, 4'hF);
        axi_write(6'h18, 32'hAABB_CCDD, 4'b0010);
        rd_chk("wstrb_byte1", 6'h18, 32'h1122_CC44);
        axi_write(6'h00, 32'h1, 4'hF);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #12 rst = 0;
        rd_chk("abort_status", 6'h04, 32'h0000_0800);
        rd_chk("abort_data0", 6'h10, 32'h0);
        rd_chk("abort_data5", 6'h24, 32'h0);

        // randomized rounds checked by the model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: v[i] = $urandom();
                    1: v[i] = 32'($urandom_range(0, 3));
                    2: v[i] = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    default: v[i] = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
                endcase
            end
            load(v);
            desc = 1'($urandom_range(0, 1));
            ien  = 1'($urandom_range(0, 1));
            axi_write(6'h00, {29'b0, ien, desc, 1'b1}, 4'hF);
            case ($urandom_range(0, 3))
                0: axi_write(6'(16 + 4 * $urandom_range(0, N - 1)), $urandom(), 4'hF);
                1: axi_write(6'h04, 32'h2, 4'hF);
                2: axi_read(6'(16 + 4 * $urandom_range(0, N - 1)), d);
                default: ;
            endcase
            wait_idle();
            for (int i = 0; i < N; i++) axi_read(6'(16 + 4*i), d);
            axi_read(6'h00, d);
            if ($urandom_range(0, 1) != 0) axi_write(6'h04, 32'h2, 4'hF);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
